// File: rtl/hazard_ctrl_fwd.sv
// hazard_ctrl_fwd: E-stage forwarding selects, load-use/legacy RAW stalls,
// single-slot MDU countdown scoreboard, jump flushes and a stall counter.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   rs*_D, rs*_used_D        D-stage sources and their used flags
//   mdu_op_D                 D-stage instruction is an MDU op
//   rs*_E, rd_E, *_E         E-stage sources, destination, controls
//   rd_M/W, reg_write_M/W    later-stage destinations
//   fwd_a_sel, fwd_b_sel     0 regfile, 1 M result, 2 W result
//   stall_F/D, flush_D       front-end hold / IF-ID zero
//   bubble_E                 NOP into ID-EX
//   mdu_busy/done/rd         MDU scoreboard state
//   stall_count              saturating count of stall_D cycles
module hazard_ctrl_fwd #(
    parameter int RA_W    = 5,
    parameter int MDU_LAT = 4,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] rs1_D,
    input  logic [RA_W-1:0] rs2_D,
    input  logic            rs1_used_D,
    input  logic            rs2_used_D,
    input  logic            mdu_op_D,
    input  logic [RA_W-1:0] rs1_E,
    input  logic [RA_W-1:0] rs2_E,
    input  logic [RA_W-1:0] rd_E,
    input  logic            reg_write_E,
    input  logic            mem_read_E,
    input  logic            mdu_start_E,
    input  logic            jump_E,
    input  logic [RA_W-1:0] rd_M,
    input  logic            reg_write_M,
    input  logic [RA_W-1:0] rd_W,
    input  logic            reg_write_W,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            stall_F,
    output logic            stall_D,
    output logic            flush_D,
    output logic            bubble_E,
    output logic            mdu_busy,
    output logic            mdu_done,
    output logic [RA_W-1:0] mdu_rd,
    output logic [CNT_W-1:0] stall_count
);
    function automatic logic f_match(input logic [RA_W-1:0] x, input logic [RA_W-1:0] y);
        return (x == y) && (x != '0);
    endfunction

    logic [3:0]       r_cnt;
    logic             r_busy;
    logic [RA_W-1:0]  r_mdu_rd;
    logic [CNT_W-1:0] r_stall_cnt;

    // Unused sources collapse to x0, which never matches.
    logic [RA_W-1:0] w_rs1_D, w_rs2_D;
    logic            w_hit_E, w_hit_M, w_hit_mdu;
    logic            w_luse, w_raw, w_mdu_hz, w_stall, w_flush, w_done;
    logic [1:0]      w_fwd_a, w_fwd_b;

    always_comb begin
        w_rs1_D   = rs1_used_D ? rs1_D : '0;
        w_rs2_D   = rs2_used_D ? rs2_D : '0;
        w_hit_E   = f_match(rd_E, w_rs1_D) || f_match(rd_E, w_rs2_D);
        w_hit_M   = f_match(rd_M, w_rs1_D) || f_match(rd_M, w_rs2_D);
        w_hit_mdu = f_match(r_mdu_rd, w_rs1_D) || f_match(r_mdu_rd, w_rs2_D);
        w_luse    = (FWD_EN != 0) && mem_read_E && reg_write_E && w_hit_E;
        w_raw     = (FWD_EN == 0) && ((reg_write_E && w_hit_E) || (reg_write_M && w_hit_M));
        // No MDU bypass: the done cycle still stalls a dependent reader.
        w_mdu_hz  = r_busy && (w_hit_mdu || mdu_op_D);
        w_stall   = rst_n && !jump_E && (w_luse || w_raw || w_mdu_hz);
        w_flush   = rst_n && jump_E;
        w_done    = rst_n && r_busy && (r_cnt == 4'd1);
        w_fwd_a   = (FWD_EN == 0 || !rst_n) ? 2'd0 :
                    (reg_write_M && f_match(rd_M, rs1_E)) ? 2'd1 :
                    (reg_write_W && f_match(rd_W, rs1_E)) ? 2'd2 : 2'd0;
        w_fwd_b   = (FWD_EN == 0 || !rst_n) ? 2'd0 :
                    (reg_write_M && f_match(rd_M, rs2_E)) ? 2'd1 :
                    (reg_write_W && f_match(rd_W, rs2_E)) ? 2'd2 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_mdu_rd    <= '0;
            r_stall_cnt <= '0;
        end else begin
            // A jump discards the E instruction, so its MDU start is dropped.
            if (mdu_start_E && !jump_E && !r_busy) begin
                r_cnt    <= 4'(MDU_LAT);
                r_mdu_rd <= rd_E;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_cnt    <= r_cnt - 4'd1;
                r_busy   <= (r_cnt != 4'd1);
            end
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_a_sel   = w_fwd_a;
    assign fwd_b_sel   = w_fwd_b;
    assign stall_F     = w_stall;
    assign stall_D     = w_stall;
    assign flush_D     = w_flush;
    assign bubble_E    = w_stall || w_flush;
    assign mdu_busy    = rst_n && r_busy;
    assign mdu_done    = w_done;
    assign mdu_rd      = rst_n ? r_mdu_rd : '0;
    assign stall_count = rst_n ? r_stall_cnt : '0;
endmodule

// File: tb/tb_hazard_ctrl_fwd.sv
// tb_hazard_ctrl_fwd: directed checks of a forwarding instance and a legacy 4-bit-counter instance.
module tb_hazard_ctrl_fwd;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       rs1_used_D, rs2_used_D, mdu_op_D, reg_write_E, mem_read_E;
    logic       mdu_start_E, jump_E, reg_write_M, reg_write_W;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_sf, a_sd, a_fl, a_be, a_busy, a_done;
    logic        b_sf, b_sd, b_fl, b_be, b_busy, b_done;
    logic [4:0]  a_mrd, b_mrd;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_fwd u_a (
        .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .mdu_op_D(mdu_op_D),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
        .mem_read_E(mem_read_E), .mdu_start_E(mdu_start_E), .jump_E(jump_E),
        .rd_M(rd_M), .reg_write_M(reg_write_M), .rd_W(rd_W), .reg_write_W(reg_write_W),
        .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_F(a_sf), .stall_D(a_sd),
        .flush_D(a_fl), .bubble_E(a_be), .mdu_busy(a_busy), .mdu_done(a_done),
        .mdu_rd(a_mrd), .stall_count(a_cnt)
    );

    hazard_ctrl_fwd #(.FWD_EN(0), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .mdu_op_D(mdu_op_D),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
        .mem_read_E(mem_read_E), .mdu_start_E(mdu_start_E), .jump_E(jump_E),
        .rd_M(rd_M), .reg_write_M(reg_write_M), .rd_W(rd_W), .reg_write_W(reg_write_W),
        .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_F(b_sf), .stall_D(b_sd),
        .flush_D(b_fl), .bubble_E(b_be), .mdu_busy(b_busy), .mdu_done(b_done),
        .mdu_rd(b_mrd), .stall_count(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {rs1_used_D, rs2_used_D, mdu_op_D, reg_write_E, mem_read_E} = '0;
        {mdu_start_E, jump_E, reg_write_M, reg_write_W} = '0;
    endtask

    initial begin
        clear();
        rst_n = 1'b0;
        tick();
        tick();
        // Reset forces outputs low even with a live forwarding match.
        rd_M = 5; reg_write_M = 1; rs1_E = 5;
        #1;
        check("rst_fwd_a", a_fa, 0);
        check("rst_busy", a_busy, 0);
        check("rst_cnt", a_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Forwarding priority M over W, and x0 never forwards.
        rd_W = 5; reg_write_W = 1; rs2_E = 6;
        #1;
        check("fwd_a_M", a_fa, 1);
        check("fwd_b_none", a_fb, 0);
        check("legacy_sel", b_fa, 0);
        reg_write_M = 0;
        #1;
        check("fwd_a_W", a_fa, 2);
        rs1_E = 0; rs2_E = 5;
        #1;
        check("fwd_a_x0", a_fa, 0);
        check("fwd_b_W", a_fb, 2);
        tick();
        clear();

        // Load-use stalls for one cycle.
        mem_read_E = 1; reg_write_E = 1; rd_E = 7; rs2_D = 7; rs2_used_D = 1;
        #1;
        check("lu_stall_F", a_sf, 1);
        check("lu_stall_D", a_sd, 1);
        check("lu_bubble", a_be, 1);
        check("lu_flush", a_fl, 0);
        tick();
        clear();
        #1;
        check("lu_release", a_sd, 0);
        check("lu_cnt", a_cnt, 1);
        mem_read_E = 1; reg_write_E = 1; rd_E = 7; rs2_D = 7; rs2_used_D = 0;
        #1;
        check("lu_unused", a_sd, 0);
        tick();

        // Jump beats a simultaneous load-use.
        rs2_used_D = 1; jump_E = 1;
        #1;
        check("jmp_flush", a_fl, 1);
        check("jmp_bubble", a_be, 1);
        check("jmp_stall_F", a_sf, 0);
        check("jmp_stall_D", a_sd, 0);
        tick();
        clear();
        #1;
        check("jmp_cnt", a_cnt, 1);

        // MDU RAW: busy 4 cycles, done in the 4th, stall through done.
        mdu_start_E = 1; reg_write_E = 1; rd_E = 9; rs1_D = 9; rs1_used_D = 1;
        #1;
        check("mdu_issue_stall", a_sd, 0);
        check("mdu_issue_busy", a_busy, 0);
        tick();
        mdu_start_E = 0; reg_write_E = 0; rd_E = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("mdu_busy%0d", k), a_busy, 1);
            check($sformatf("mdu_done%0d", k), a_done, (k == 4) ? 1 : 0);
            check($sformatf("mdu_stall%0d", k), a_sd, 1);
            check($sformatf("mdu_rd%0d", k), a_mrd, 9);
            tick();
        end
        #1;
        check("mdu_end_busy", a_busy, 0);
        check("mdu_end_done", a_done, 0);
        check("mdu_end_stall", a_sd, 0);
        check("mdu_cnt", a_cnt, 5);
        clear();

        // Structural stall: another MDU op in D while busy.
        mdu_start_E = 1; rd_E = 10;
        tick();
        clear();
        mdu_op_D = 1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("struct_stall%0d", k), a_sd, 1);
            tick();
        end
        #1;
        check("struct_release", a_sd, 0);
        check("struct_cnt", a_cnt, 9);
        clear();

        // Reset two cycles into an MDU op abandons it.
        mdu_start_E = 1; rd_E = 11;
        tick();
        clear();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mdu_busy", a_busy, 0);
        check("rst_mdu_done", a_done, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("post_rst_done%0d", k), a_done, 0);
            check($sformatf("post_rst_busy%0d", k), a_busy, 0);
            tick();
        end
        check("post_rst_cnt", a_cnt, 0);

        // Legacy stall-only mode.
        reg_write_M = 1; rd_M = 3; rs1_D = 3; rs1_used_D = 1; rs1_E = 3;
        #1;
        check("leg_stall", b_sd, 1);
        check("leg_fwd_a", b_fa, 0);
        check("leg_fwd_b", b_fb, 0);
        check("fwd_mode_nostall", a_sd, 0);
        check("fwd_mode_sel", a_fa, 1);
        rd_M = 0; rs1_D = 0;
        #1;
        check("leg_x0", b_sd, 0);
        tick();
        rd_M = 3; rs1_D = 3;
        for (int k = 0; k < 20; k++) tick();
        check("leg_sat", b_cnt, 15);
        check("fwd_cnt_idle", a_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_fwd.md
Name: hazard_ctrl_fwd

Overview:
- Next-generation pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Generates operand-forwarding selects for the E stage and load-use stalls.
- Tracks one outstanding multi-cycle multiply/divide (MDU) op with a countdown scoreboard, and produces redirect flushes.
- FWD_EN=0 selects legacy stall-only mode; also keeps a saturating stall-cycle performance counter.

Parameters:
- RA_W, 5: register address width; register 0 is hardwired zero.
- MDU_LAT, 4: MDU busy cycles after issue (legal range 1..15).
- FWD_EN, 1: 1 = forwarding mode, 0 = stall-only mode (stall on any E/M RAW match).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- rs1_D, rs2_D  in  RA_W  source registers of the instruction in D
- rs1_used_D, rs2_used_D  in  1  source operand actually read
- mdu_op_D  in  1  instruction in D is an MDU op
- rs1_E, rs2_E  in  RA_W  source registers of the instruction in E
- rd_E  in  RA_W  destination in E
- reg_write_E  in  1  E writes rd
- mem_read_E  in  1  E is a load
- mdu_start_E  in  1  E is an MDU op issuing this cycle
- jump_E  in  1  taken jump/branch resolved in E
- rd_M, reg_write_M  in  RA_W, 1  M-stage destination and write enable
- rd_W, reg_write_W  in  RA_W, 1  W-stage destination and write enable
- fwd_a_sel, fwd_b_sel  out  2  operand source: 0 regfile, 1 M result, 2 W result (3 unused)
- stall_F, stall_D  out  1  hold PC / IF-ID register
- flush_D  out  1  zero the IF-ID register
- bubble_E  out  1  insert NOP into ID-EX
- mdu_busy  out  1  MDU op outstanding
- mdu_done  out  1  one-cycle pulse; MDU result written back this cycle
- mdu_rd  out  RA_W  destination of the outstanding MDU op
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: when rst_n is low at a clock edge, the following clear: MDU counter, busy, mdu_rd and stall_count.
  - While rst_n is low, every output is forced to 0.
  - Reset during an MDU op abandons it; no mdu_done pulse is produced.
- Matching rule: match(x,y) = (x==y) && (x!=0). A source participates only if its used flag is 1 (D stage).
- Forwarding (FWD_EN=1, combinational):
  - fwd_a_sel=1 if reg_write_M && match(rd_M,rs1_E).
  - Otherwise fwd_a_sel=2 if reg_write_W && match(rd_W,rs1_E).
  - Otherwise fwd_a_sel=0. M has priority over W.
  - fwd_b_sel follows the same rule using rs2_E.
  - With FWD_EN=0, both selects are constant 0.
- Load-use (FWD_EN=1): luse = mem_read_E && reg_write_E && match(rd_E, used rs of D).
- Legacy RAW (FWD_EN=0): raw = (reg_write_E && match(rd_E, used rs of D)) || (reg_write_M && match(rd_M, used rs of D)).
- MDU scoreboard:
  - An accepted mdu_start_E loads cnt<=MDU_LAT, mdu_rd<=rd_E and busy<=1.
  - cnt decrements each cycle.
  - mdu_done=1 when busy && cnt==1; busy clears on the following edge. busy is therefore high for exactly MDU_LAT cycles.
  - mdu_raw = busy && match(mdu_rd, used rs of D). This includes the done cycle; there is no MDU bypass.
  - mdu_struct = busy && mdu_op_D.
  - mdu_start_E while busy cannot occur, because of mdu_struct.
- Priority (highest first): reset > jump_E > (mdu_raw | mdu_struct | luse | raw).
  - jump_E=1: flush_D=1, bubble_E=1, stall_F=0, stall_D=0. Any pending stall is dropped because the D instruction is discarded.
  - Stall condition without jump: stall_F=1, stall_D=1, bubble_E=1, flush_D=0.
  - Otherwise all four outputs are 0.
- jump_E and mdu_start_E are never asserted together (same E instruction). If they are, jump wins and the MDU start is ignored.
- A stall lasts exactly as long as its condition: load-use is 1 cycle; MDU RAW lasts until the cycle after mdu_done.
- stall_count increments on each cycle with stall_D=1 and saturates at 2^CNT_W-1. It is not incremented on flush cycles.

Test Plan:
- Forwarding: rd_M=5 with reg_write_M=1, rd_W=5 with reg_write_W=1, rs1_E=5, rs2_E=6 → fwd_a_sel=1, fwd_b_sel=0. Then drop reg_write_M → fwd_a_sel=2. Repeat with rs1_E=0 → fwd_a_sel=0.
- Load-use: mem_read_E=1, rd_E=7, rs2_D=7, rs2_used_D=1 → stall_F/stall_D/bubble_E high for 1 cycle and stall_count=1. The same case with rs2_used_D=0 gives no stall.
- MDU, MDU_LAT=4: mdu_start_E with rd_E=9, next D reads x9:
  - mdu_busy is high for 4 cycles and mdu_done pulses in the 4th.
  - Stall holds through the done cycle and releases the cycle after.
  - A second mdu_op_D during busy also stalls.
- Redirect vs stall: jump_E=1 in the same cycle as load-use → flush_D=1, bubble_E=1, stall_F=0, stall_D=0, and stall_count is unchanged.
- Legacy mode, FWD_EN=0: reg_write_M=1, rd_M=3, rs1_D=3 → stall, with both selects 0. rd_M=0 with rs1_D=0 → no stall.
- Reset and saturation:
  - Assert rst_n=0 two cycles into an MDU op → busy=0 and no done pulse.
  - With CNT_W=4, hold a stall for 20 cycles → stall_count=15.
